// File: rtl/clipsafe_wb_regs.sv
// -----------------------------------------------------------------------------
// clipsafe_wb_regs
//
// Wishbone classic responder holding the control/status registers of the
// CLIP-SAFE analog block. It drives the eight digital GPIO outputs and their
// enables, samples the three digital GPIO inputs, counts trip events seen on
// io_in[0], and raises a level-sensitive user interrupt while a trip is
// pending.
//
// Ports:
//   wb_clk_i   in   1   sole clock, all state changes on the rising edge
//   wb_rst_i   in   1   asynchronous, active-high reset
//   wbs_stb_i  in   1   strobe
//   wbs_cyc_i  in   1   bus cycle valid
//   wbs_we_i   in   1   1 = write, 0 = read
//   wbs_sel_i  in   4   byte-lane enables for writes
//   wbs_dat_i  in  32   write data
//   wbs_adr_i  in  32   byte address
//   wbs_ack_o  out  1   registered single-cycle acknowledge
//   wbs_dat_o  out 32   registered read data, 0 whenever ack is low
//   io_in      in   3   digital GPIO inputs, bit0 = trip comparator
//   io_out     out  8   GPIO output values
//   io_oeb     out  8   GPIO output enables, active low
//   user_irq   out  3   bit0 = trip interrupt, bits 2:1 tied low
//
// Register map (offset = wbs_adr_i[7:0], bits [1:0] ignored):
//   0x00 CTRL   R/W  [0] enable, [1] irq_en, [2] cnt_clr (write-1 pulse, reads 0)
//   0x04 GPIO   R/W  [7:0] io_out, [15:8] io_oeb
//   0x08 STATUS      [2:0] synchronized io_in (RO), [8] trip sticky (W1C)
//   0x0C COUNT  RO   zero-extended trip counter
//   0x10 ID     RO   ID_VALUE
//   other offsets in the window read 0, ignore writes and are still acked.
// -----------------------------------------------------------------------------
module clipsafe_wb_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE  = 32'hC115_AFE1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [2:0]  io_in,
    output logic [7:0]  io_out,
    output logic [7:0]  io_oeb,
    output logic [2:0]  user_irq
);

    // Word offsets inside the 256-byte window.
    localparam logic [5:0] OFS_CTRL   = 6'h00;
    localparam logic [5:0] OFS_GPIO   = 6'h01;
    localparam logic [5:0] OFS_STATUS = 6'h02;
    localparam logic [5:0] OFS_COUNT  = 6'h03;
    localparam logic [5:0] OFS_ID     = 6'h04;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -------------------------------------------------------------------------
    // Handshake: a request is accepted when cyc and stb are both high, the
    // address falls in the window and no ack is currently being presented.
    // An accepted request raises ack for exactly one cycle after the sampling
    // edge; the ~ack term forces a held request to be accepted only every
    // other cycle. Writes take effect and read data is captured on that same
    // edge. Addresses outside the window are never acknowledged.
    // -------------------------------------------------------------------------
    logic       hit;
    logic       req;
    logic       wr_req;
    logic       rd_req;
    logic [5:0] word;

    // State registers
    logic             ack_q,      ack_d;
    logic [31:0]      dat_q,      dat_d;
    logic             enable_q,   enable_d;
    logic             irq_en_q,   irq_en_d;
    logic [7:0]       gpio_out_q, gpio_out_d;
    logic [7:0]       gpio_oeb_q, gpio_oeb_d;
    logic             trip_q,     trip_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             irq_q,      irq_d;

    // Input synchronizer and edge-detect history
    logic [2:0]       sync1_q,    sync1_d;
    logic [2:0]       sync2_q,    sync2_d;
    logic             prev_q,     prev_d;

    // Combinational helpers
    logic             rise;
    logic             trip_event;
    logic             cnt_clr;
    logic             trip_w1c;
    logic [31:0]      cnt_ext;
    logic [31:0]      rdata;

    // Bits of the bus that carry no meaning for this register set.
    logic             unused_bus_bits;
    assign unused_bus_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16]};

    assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req    = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
    assign wr_req = req & wbs_we_i;
    assign rd_req = req & ~wbs_we_i;
    assign word   = wbs_adr_i[7:2];

    // Rising edge of the synchronized trip comparator. prev_q is one stage
    // behind sync2_q, so an io_in[0] edge becomes a trip on the third edge.
    assign rise = sync2_q[0] & ~prev_q;

    // -------------------------------------------------------------------------
    // Read mux: returns the values held before any write on the same edge.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_ext = '0;
        cnt_ext[CNT_W-1:0] = cnt_q;
    end

    always_comb begin
        rdata = '0;
        case (word)
            OFS_CTRL:   rdata[1:0]  = {irq_en_q, enable_q};
            OFS_GPIO:   rdata[15:0] = {gpio_oeb_q, gpio_out_q};
            OFS_STATUS: begin
                rdata[2:0] = sync2_q;
                rdata[8]   = trip_q;
            end
            OFS_COUNT:  rdata       = cnt_ext;
            OFS_ID:     rdata       = ID_VALUE;
            default:    rdata       = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        ack_d      = req;
        dat_d      = rd_req ? rdata : '0;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        gpio_out_d = gpio_out_q;
        gpio_oeb_d = gpio_oeb_q;
        trip_d     = trip_q;
        cnt_d      = cnt_q;
        cnt_clr    = 1'b0;
        trip_w1c   = 1'b0;
        trip_event = 1'b0;

        sync1_d    = io_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q[0];

        // The interrupt follows trip and irq_en with one cycle of delay.
        irq_d      = trip_q & irq_en_q;

        if (wr_req) begin
            case (word)
                OFS_CTRL: begin
                    if (wbs_sel_i[0]) begin
                        enable_d = wbs_dat_i[0];
                        irq_en_d = wbs_dat_i[1];
                        cnt_clr  = wbs_dat_i[2];
                    end
                end
                OFS_GPIO: begin
                    if (wbs_sel_i[0]) gpio_out_d = wbs_dat_i[7:0];
                    if (wbs_sel_i[1]) gpio_oeb_d = wbs_dat_i[15:8];
                end
                OFS_STATUS: begin
                    if (wbs_sel_i[1]) trip_w1c = wbs_dat_i[8];
                end
                default: begin
                end
            endcase
        end

        // Edge qualification uses the enable in force before this edge.
        trip_event = rise & enable_q;

        // A new trip beats a simultaneous W1C so no event is lost.
        if (trip_event) begin
            trip_d = 1'b1;
        end else if (trip_w1c) begin
            trip_d = 1'b0;
        end

        // A counter clear beats a simultaneous trip; the counter saturates.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (trip_event && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            gpio_out_q <= 8'h00;
            gpio_oeb_q <= 8'hFF;
            trip_q     <= 1'b0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            gpio_out_q <= gpio_out_d;
            gpio_oeb_q <= gpio_oeb_d;
            trip_q     <= trip_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = gpio_out_q;
    assign io_oeb    = gpio_oeb_q;
    assign user_irq  = {2'b00, irq_q};

endmodule
